// File: rtl/acx_dm_pcie_link_sequencer.sv
// acx_dm_pcie_link_sequencer
//   Sequences Device Manager bring-up and the PCIE_1 reset/link flow for the user fabric.
//   Starts the DM once the fabric PLL locks. Waits for DM config-done, PERSTN release and
//   a stable LTSSM L0. Then releases the user-logic reset and reports link state and faults.
//
// Optional feature macro: ACX_DM_SEQ_HOTRST_EN
//   defined   : hot reset in RUN drops back to LINK_WAIT and is counted on o_hotrst_cnt
//   undefined : hot reset is an ordinary non-L0 state, o_hotrst_cnt is tied to 0
//
// Ports
//   i_clk          100 MHz clock, shared with the DM
//   i_reset        asynchronous active-high reset (released synchronously by the system)
//   i_pll_lock     fabric PLL locked, asynchronous, 2-flop synchronised
//   i_dm_status    DM o_status word
//   i_pcie_perstn  PCIE_1 PERSTN, asynchronous, 2-flop synchronised
//   i_ltssm_state  PCIE_1 LTSSM state
//   o_dm_start     DM start request, held once issued
//   o_user_rstn    user-logic reset, active-low
//   o_link_up      link stable in L0
//   o_timeout_err  a wait state ran out of time
//   o_dm_err       DM reported an error
//   o_state        FSM state encoding
//   o_hotrst_cnt   saturating hot-reset event count
module acx_dm_pcie_link_sequencer #(
   parameter int unsigned DM_DONE_BIT     = 5,
   parameter int unsigned DM_ERR_BIT      = 31,
   parameter logic [5:0]  LTSSM_L0        = 6'h11,
   parameter logic [5:0]  LTSSM_HOTRST    = 6'h1F,
   parameter int unsigned LINK_STABLE_CYC = 256,
   parameter int unsigned TIMEOUT_CYC     = 100_000_000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_pll_lock,
   input  logic [31:0] i_dm_status,
   input  logic        i_pcie_perstn,
   input  logic [5:0]  i_ltssm_state,
   output logic        o_dm_start,
   output logic        o_user_rstn,
   output logic        o_link_up,
   output logic        o_timeout_err,
   output logic        o_dm_err,
   output logic [2:0]  o_state,
   output logic [7:0]  o_hotrst_cnt
);

   localparam int unsigned SW = $clog2(LINK_STABLE_CYC + 1);

   typedef enum logic [2:0] {
      StIdle      = 3'd0,
      StDmWait    = 3'd1,
      StPerstWait = 3'd2,
      StLinkWait  = 3'd3,
      StRun       = 3'd4,
      StError     = 3'd5
   } state_e;

   state_e        state;
   logic          lock_meta, lock_sync;
   logic          perst_meta, perst_sync;
   logic [31:0]   tmo_cnt;
   logic [SW-1:0] stable_cnt;
   logic          dm_done, dm_fault, in_l0, tmo_hit, stable_hit;

   // Only two status bits matter; fold the rest so they are visibly intentional.
   logic unused_status;
   assign unused_status = ^i_dm_status;

   assign dm_done    = i_dm_status[DM_DONE_BIT];
   assign dm_fault   = i_dm_status[DM_ERR_BIT];
   assign in_l0      = (i_ltssm_state == LTSSM_L0);
   assign tmo_hit    = (tmo_cnt == 32'(TIMEOUT_CYC - 1));
   assign stable_hit = (stable_cnt == SW'(LINK_STABLE_CYC - 1));
   assign o_state    = state;

`ifdef ACX_DM_SEQ_HOTRST_EN
   logic       hot_match, hot_prev;
   logic [7:0] hotrst_cnt;
   assign hot_match    = (i_ltssm_state == LTSSM_HOTRST);
   assign o_hotrst_cnt = hotrst_cnt;
`else
   assign o_hotrst_cnt = 8'h00;
`endif

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         lock_meta  <= 1'b0;
         lock_sync  <= 1'b0;
         perst_meta <= 1'b0;
         perst_sync <= 1'b0;
      end else begin
         lock_meta  <= i_pll_lock;
         lock_sync  <= lock_meta;
         perst_meta <= i_pcie_perstn;
         perst_sync <= perst_meta;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state         <= StIdle;
         o_dm_start    <= 1'b0;
         o_user_rstn   <= 1'b0;
         o_link_up     <= 1'b0;
         o_timeout_err <= 1'b0;
         o_dm_err      <= 1'b0;
         tmo_cnt       <= '0;
         stable_cnt    <= '0;
`ifdef ACX_DM_SEQ_HOTRST_EN
         hot_prev      <= 1'b0;
         hotrst_cnt    <= 8'h00;
`endif
      end else begin
`ifdef ACX_DM_SEQ_HOTRST_EN
         hot_prev <= hot_match;
`endif
         unique case (state)
            StIdle: begin
               if (lock_sync) begin
                  state      <= StDmWait;
                  o_dm_start <= 1'b1;
                  tmo_cnt    <= '0;
               end
            end
            StDmWait: begin
               if (tmo_hit) begin
                  state         <= StError;
                  o_timeout_err <= 1'b1;
               end else if (dm_done) begin
                  state   <= StPerstWait;
                  tmo_cnt <= '0;
               end else begin
                  tmo_cnt <= tmo_cnt + 32'd1;
               end
            end
            StPerstWait: begin
               if (tmo_hit) begin
                  state         <= StError;
                  o_timeout_err <= 1'b1;
               end else if (perst_sync) begin
                  state      <= StLinkWait;
                  tmo_cnt    <= '0;
                  stable_cnt <= '0;
               end else begin
                  tmo_cnt <= tmo_cnt + 32'd1;
               end
            end
            StLinkWait: begin
               if (!perst_sync) begin
                  state   <= StPerstWait;
                  tmo_cnt <= '0;
               end else if (tmo_hit) begin
                  state         <= StError;
                  o_timeout_err <= 1'b1;
               end else if (in_l0 && stable_hit) begin
                  state       <= StRun;
                  o_link_up   <= 1'b1;
                  o_user_rstn <= 1'b1;
                  stable_cnt  <= '0;
               end else begin
                  tmo_cnt    <= tmo_cnt + 32'd1;
                  // Any non-L0 cycle restarts the stability window.
                  stable_cnt <= in_l0 ? stable_cnt + 1'b1 : '0;
               end
            end
            StRun: begin
               if (!perst_sync) begin
                  state       <= StPerstWait;
                  o_link_up   <= 1'b0;
                  o_user_rstn <= 1'b0;
                  tmo_cnt     <= '0;
               end
`ifdef ACX_DM_SEQ_HOTRST_EN
               else if (hot_match) begin
                  state       <= StLinkWait;
                  o_link_up   <= 1'b0;
                  o_user_rstn <= 1'b0;
                  tmo_cnt     <= '0;
                  stable_cnt  <= '0;
                  if (!hot_prev && (hotrst_cnt != 8'hFF)) hotrst_cnt <= hotrst_cnt + 8'd1;
               end
`endif
               else if (!in_l0) begin
                  // Link dropped out of L0: report it but keep user logic out of reset.
                  o_link_up  <= 1'b0;
                  stable_cnt <= '0;
               end else if (!o_link_up) begin
                  if (stable_hit) begin
                     o_link_up  <= 1'b1;
                     stable_cnt <= '0;
                  end else begin
                     stable_cnt <= stable_cnt + 1'b1;
                  end
               end
            end
            StError: begin
            end
            default: state <= StError;
         endcase

         // DM error overrides whatever the case above decided this cycle.
         if (dm_fault && (state != StIdle)) begin
            state       <= StError;
            o_dm_err    <= 1'b1;
            o_user_rstn <= 1'b0;
            o_link_up   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_acx_dm_pcie_link_sequencer.sv
// Testbench for acx_dm_pcie_link_sequencer with LINK_STABLE_CYC=4, TIMEOUT_CYC=1000.
// Observed outputs are packed as {state, dm_start, user_rstn, link_up, timeout_err, dm_err,
// hotrst_cnt} and compared after each rising edge.
module tb_acx_dm_pcie_link_sequencer;

   localparam logic [5:0]  L0   = 6'h11;
   localparam logic [5:0]  HOT  = 6'h1F;
   localparam logic [5:0]  OFF  = 6'h0C;
   localparam logic [31:0] DONE = 32'h0000_0020;
   localparam logic [31:0] DERR = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        lock = 1'b0;
   logic [31:0] status = '0;
   logic        perstn = 1'b0;
   logic [5:0]  ltssm = '0;
   logic        dm_start, user_rstn, link_up, timeout_err, dm_err;
   logic [2:0]  state;
   logic [7:0]  hot_cnt;
   logic [15:0] obs;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   acx_dm_pcie_link_sequencer #(
      .LINK_STABLE_CYC (4),
      .TIMEOUT_CYC     (1000)
   ) dut (
      .i_clk         (clk),
      .i_reset       (rst),
      .i_pll_lock    (lock),
      .i_dm_status   (status),
      .i_pcie_perstn (perstn),
      .i_ltssm_state (ltssm),
      .o_dm_start    (dm_start),
      .o_user_rstn   (user_rstn),
      .o_link_up     (link_up),
      .o_timeout_err (timeout_err),
      .o_dm_err      (dm_err),
      .o_state       (state),
      .o_hotrst_cnt  (hot_cnt)
   );

   assign obs = {state, dm_start, user_rstn, link_up, timeout_err, dm_err, hot_cnt};

   typedef struct {
      bit          pre_rst;
      logic        lock;
      logic [31:0] status;
      logic        perstn;
      logic [5:0]  ltssm;
      logic [15:0] exp;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [15:0] ex(input logic [2:0] s, input logic st, input logic rn,
                                      input logic up, input logic tmo, input logic de,
                                      input logic [7:0] h);
      return {s, st, rn, up, tmo, de, h};
   endfunction

   function automatic vec_t mk(input bit r, input logic [31:0] st, input logic [5:0] lt,
                               input logic [15:0] e);
      vec_t v;
      v.pre_rst = r;
      v.lock    = 1'b1;
      v.status  = st;
      v.perstn  = 1'b1;
      v.ltssm   = lt;
      v.exp     = e;
      return v;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      lock   = 1'b0;
      status = '0;
      perstn = 1'b0;
      ltssm  = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Reset, apply nominal inputs and wait (bounded) for the target state.
   task automatic bring_up(input logic [5:0] lt, input logic [2:0] target);
      int n;
      do_reset();
      lock   = 1'b1;
      status = DONE;
      perstn = 1'b1;
      ltssm  = lt;
      n = 0;
      while (state != target && n < 50) begin
         step(1);
         n++;
      end
      check("bring_up_state", {13'd0, state}, {13'd0, target});
   endtask

   initial begin
      // Nominal bring-up.
      tbl.push_back(mk(1, DONE, L0, ex(3'd0, 0, 0, 0, 0, 0, 8'd0)));
      tbl.push_back(mk(0, DONE, L0, ex(3'd0, 0, 0, 0, 0, 0, 8'd0)));
      tbl.push_back(mk(0, DONE, L0, ex(3'd1, 1, 0, 0, 0, 0, 8'd0)));
      tbl.push_back(mk(0, DONE, L0, ex(3'd2, 1, 0, 0, 0, 0, 8'd0)));
      for (int k = 0; k < 4; k++) tbl.push_back(mk(0, DONE, L0, ex(3'd3, 1, 0, 0, 0, 0, 8'd0)));
      tbl.push_back(mk(0, DONE, L0, ex(3'd4, 1, 1, 1, 0, 0, 8'd0)));
      // Glitchy link: reaches LINK_WAIT with ltssm idle, then L0 x3, glitch, L0 x4.
      tbl.push_back(mk(1, DONE, 6'h00, ex(3'd0, 0, 0, 0, 0, 0, 8'd0)));
      tbl.push_back(mk(0, DONE, 6'h00, ex(3'd0, 0, 0, 0, 0, 0, 8'd0)));
      tbl.push_back(mk(0, DONE, 6'h00, ex(3'd1, 1, 0, 0, 0, 0, 8'd0)));
      tbl.push_back(mk(0, DONE, 6'h00, ex(3'd2, 1, 0, 0, 0, 0, 8'd0)));
      tbl.push_back(mk(0, DONE, 6'h00, ex(3'd3, 1, 0, 0, 0, 0, 8'd0)));
      for (int k = 0; k < 3; k++) tbl.push_back(mk(0, DONE, L0, ex(3'd3, 1, 0, 0, 0, 0, 8'd0)));
      tbl.push_back(mk(0, DONE, OFF, ex(3'd3, 1, 0, 0, 0, 0, 8'd0)));
      for (int k = 0; k < 3; k++) tbl.push_back(mk(0, DONE, L0, ex(3'd3, 1, 0, 0, 0, 0, 8'd0)));
      tbl.push_back(mk(0, DONE, L0, ex(3'd4, 1, 1, 1, 0, 0, 8'd0)));
      // Link drop in RUN: link_up falls, user reset stays released, recovers after 4 L0.
      tbl.push_back(mk(0, DONE, OFF, ex(3'd4, 1, 1, 0, 0, 0, 8'd0)));
      for (int k = 0; k < 3; k++) tbl.push_back(mk(0, DONE, L0, ex(3'd4, 1, 1, 0, 0, 0, 8'd0)));
      tbl.push_back(mk(0, DONE, L0, ex(3'd4, 1, 1, 1, 0, 0, 8'd0)));
      // Hot reset for two cycles, then four L0 cycles.
`ifdef ACX_DM_SEQ_HOTRST_EN
      for (int k = 0; k < 2; k++) tbl.push_back(mk(0, DONE, HOT, ex(3'd3, 1, 0, 0, 0, 0, 8'd1)));
      for (int k = 0; k < 3; k++) tbl.push_back(mk(0, DONE, L0, ex(3'd3, 1, 0, 0, 0, 0, 8'd1)));
      tbl.push_back(mk(0, DONE, L0, ex(3'd4, 1, 1, 1, 0, 0, 8'd1)));
`else
      for (int k = 0; k < 2; k++) tbl.push_back(mk(0, DONE, HOT, ex(3'd4, 1, 1, 0, 0, 0, 8'd0)));
      for (int k = 0; k < 3; k++) tbl.push_back(mk(0, DONE, L0, ex(3'd4, 1, 1, 0, 0, 0, 8'd0)));
      tbl.push_back(mk(0, DONE, L0, ex(3'd4, 1, 1, 1, 0, 0, 8'd0)));
`endif

      do_reset();
      check("reset_state", obs, 16'h0000);

      foreach (tbl[i]) begin
         if (tbl[i].pre_rst) do_reset();
         lock   = tbl[i].lock;
         status = tbl[i].status;
         perstn = tbl[i].perstn;
         ltssm  = tbl[i].ltssm;
         step(1);
         check($sformatf("vec%0d", i), obs, tbl[i].exp);
      end

      // Timeout in DM_WAIT: DM_WAIT entered on edge 3, ERROR 1000 edges later.
      do_reset();
      lock   = 1'b1;
      perstn = 1'b1;
      step(3);
      check("tmo_enter_dm_wait", obs, ex(3'd1, 1, 0, 0, 0, 0, 8'd0));
      step(999);
      check("tmo_not_yet", obs, ex(3'd1, 1, 0, 0, 0, 0, 8'd0));
      step(1);
      check("tmo_error", obs, ex(3'd5, 1, 0, 0, 1, 0, 8'd0));
      status = DONE;
      step(5);
      check("tmo_sticky", obs, ex(3'd5, 1, 0, 0, 1, 0, 8'd0));

      // PERSTN assertion in RUN, then recovery.
      bring_up(L0, 3'd4);
      perstn = 1'b0;
      step(2);
      check("perst_sync_latency", obs, ex(3'd4, 1, 1, 1, 0, 0, 8'd0));
      step(1);
      check("perst_to_wait", obs, ex(3'd2, 1, 0, 0, 0, 0, 8'd0));
      perstn = 1'b1;
      step(3);
      check("perst_to_link_wait", obs, ex(3'd3, 1, 0, 0, 0, 0, 8'd0));
      step(3);
      check("perst_link_stabilising", obs, ex(3'd3, 1, 0, 0, 0, 0, 8'd0));
      step(1);
      check("perst_back_to_run", obs, ex(3'd4, 1, 1, 1, 0, 0, 8'd0));

      // DM error in LINK_WAIT, sticky ERROR.
      bring_up(6'h00, 3'd3);
      status = DONE | DERR;
      step(1);
      check("dm_err_entry", obs, ex(3'd5, 1, 0, 0, 0, 1, 8'd0));
      status = DONE;
      step(3);
      check("dm_err_sticky", obs, ex(3'd5, 1, 0, 0, 0, 1, 8'd0));

      // Asynchronous reset mid-cycle while in RUN.
      bring_up(L0, 3'd4);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("async_reset", obs, 16'h0000);
      @(posedge clk);
      #1 rst = 1'b0;
      step(2);
      check("post_reset_sync_idle", obs, 16'h0000);
      step(1);
      check("post_reset_restart", obs, ex(3'd1, 1, 0, 0, 0, 0, 8'd0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
